pc_redirect_unit: RTL and testbench
===================================

# pc_redirect_unit

Fetch-side consumer of the execute-stage branch/jump decision. Owns the architectural fetch PC and drives the instruction-memory request address. It applies taken-branch/jump redirects from the X stage, kills wrong-path instructions in F/D for a fixed number of advancing cycles, and traps misaligned targets. It also keeps a redirect performance counter.

## Interface
- RESET_PC, 32'h0000_2000, fetch address after reset
- TRAP_PC, 32'h0000_1000, fetch address on misaligned-target trap
- FLUSH_CYCLES, 2, number of advancing cycles F/D are killed after a redirect (legal 1..7)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- x_valid  in  1  X stage holds a valid, non-killed instruction
- x_pc_sel  in  1  X control requests PC redirect (taken branch, JAL, JALR)
- x_jalr  in  1  X instruction is JALR; clear target bit 0
- x_target  in  32  ALU-computed target address
- stall_in  in  1  pipeline frozen this cycle; no stage advances
- imem_ready  in  1  instruction memory accepts imem_addr this cycle
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address (= pc_q)
- flush_fd  out  1  kill instructions in F and D this cycle
- trap_misalign  out  1  one-cycle pulse: misaligned target trapped
- trap_epc  out  32  X-stage target that caused the last trap (sticky)
- redirect_count  out  32  number of accepted redirects, wraps

## Operation
- Redirect event R = x_valid & x_pc_sel & !stall_in & (state != BOOT).
- Effective target T = x_jalr ? {x_target[31:1],1'b0} : x_target. Misaligned M = (T[1:0] != 2'b00).
- States:
  - BOOT: the cycle after reset release. imem_req=0, flush_fd=1. Goes to RUN unconditionally.
  - RUN: imem_req=1, flush_fd=R.
  - FLUSH: imem_req=1, flush_fd=1.
- PC update, priority order:
  - R & !M: pc_q <= T.
  - R & M: pc_q <= TRAP_PC, trap_misalign=1 next cycle, trap_epc <= T.
  - else if imem_req & imem_ready & !stall_in: pc_q <= pc_q + 4, mod 2^32.
  - else hold.
  - A redirect discards the current fetch regardless of imem_ready.
- Flush counter cnt, 3 bits:
  - On R: cnt <= FLUSH_CYCLES-1, state -> FLUSH, or RUN if FLUSH_CYCLES==1.
  - In FLUSH: cnt decrements only when !stall_in. When cnt==1 and !stall_in, state -> RUN next cycle.
  - A new R in FLUSH reloads cnt and re-applies the target; this is not expected, since X carries killed bubbles, but it must be handled.
- redirect_count increments on every R, trapped or not, and wraps 32'hFFFF_FFFF -> 0.
- Reset (any time, including mid-flush): state=BOOT, pc_q=RESET_PC, cnt=0, redirect_count=0, trap_epc=0, trap_misalign=0.
- Reset outputs: imem_req=0, imem_addr=RESET_PC, flush_fd=1.

## Timing
- Redirect latency:
  - R in cycle N: flush_fd=1 in N.
  - imem_addr=T (or TRAP_PC) from N+1.
  - flush_fd stays 1 through the next FLUSH_CYCLES-1 non-stalled cycles after N.
- stall_in=1 freezes pc_q, cnt, state. flush_fd holds its value. R is suppressed.
- x_valid, x_pc_sel, x_target, x_jalr, stall_in and imem_ready are sampled combinationally. flush_fd is combinational from R.
- Sequential advance requires imem_ready=1. With imem_ready=0, imem_addr holds and imem_req stays 1.
- trap_misalign is registered: high exactly one cycle, N+1.

## Test plan
- Reset/boot: hold rst_n=0, release, imem_ready=1 -> cycle 0 imem_req=0 and flush_fd=1; then addresses 0x2000, 0x2004, 0x2008; flush_fd=0.
- Taken branch, FLUSH_CYCLES=2: R at pc 0x2008 with x_target=0x2040 -> flush_fd=1 for 2 cycles; imem_addr=0x2040 next cycle, then 0x2044; redirect_count=1.
- JALR bit clear: x_jalr=1, x_target=0x3001 -> imem_addr=0x3000; no trap.
- Misaligned: x_target=0x2042, x_jalr=0 -> imem_addr=0x1000; trap_misalign pulses once; trap_epc=0x2042; redirect_count increments.
- Stall inside flush: R, then stall_in=1 for 3 cycles -> flush_fd stays 1 and pc_q holds; flush ends one non-stalled cycle after the stall releases. With x_pc_sel=1 during the stall, no redirect occurs.
- Backpressure and reset mid-flush: imem_ready=0 for 4 cycles -> imem_addr constant. Assert rst_n=0 during FLUSH -> outputs return to reset values immediately, and redirect_count=0.

Source files
------------

// File: rtl/pc_redirect_unit.sv
// Fetch PC owner: applies X-stage redirects, kills wrong-path F/D instructions for a fixed
// number of advancing cycles, traps misaligned targets and counts redirects.
module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_2000,
    parameter logic [31:0] TRAP_PC      = 32'h0000_1000,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        x_valid_i,
    input  logic        x_pc_sel_i,
    input  logic        x_jalr_i,
    input  logic [31:0] x_target_i,
    input  logic        stall_in_i,
    input  logic        imem_ready_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    output logic        flush_fd_o,
    output logic        trap_misalign_o,
    output logic [31:0] trap_epc_o,
    output logic [31:0] redirect_count_o
);

    localparam logic [1:0] StBoot  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StFlush = 2'd2;

    localparam logic [2:0] CntLoad = 3'(FLUSH_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] count_q, count_d;
    logic [31:0] epc_q, epc_d;
    logic        trap_q, trap_d;

    logic        redirect;
    logic        misalign;
    logic [31:0] tgt;

    assign tgt      = x_jalr_i ? {x_target_i[31:1], 1'b0} : x_target_i;
    assign misalign = |tgt[1:0];
    assign redirect = x_valid_i & x_pc_sel_i & ~stall_in_i & (state_q != StBoot);

    assign imem_req_o       = (state_q != StBoot);
    assign imem_addr_o      = pc_q;
    // Boot and flush always kill; in run only a live redirect does.
    assign flush_fd_o       = (state_q != StRun) | redirect;
    assign trap_misalign_o  = trap_q;
    assign trap_epc_o       = epc_q;
    assign redirect_count_o = count_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        count_d = count_q;
        epc_d   = epc_q;
        trap_d  = 1'b0;
        if (redirect) begin
            count_d = count_q + 32'd1;
            trap_d  = misalign;
            cnt_d   = CntLoad;
            state_d = (FLUSH_CYCLES == 1) ? StRun : StFlush;
            if (misalign) begin
                pc_d  = TRAP_PC;
                epc_d = tgt;
            end else begin
                pc_d  = tgt;
            end
        end else begin
            if (imem_req_o && imem_ready_i && !stall_in_i) begin
                pc_d = pc_q + 32'd4;
            end
            unique case (state_q)
                StBoot:  state_d = StRun;
                StFlush: begin
                    if (!stall_in_i) begin
                        cnt_d = cnt_q - 3'd1;
                        if (cnt_q == 3'd1) begin
                            state_d = StRun;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StBoot;
            pc_q    <= RESET_PC;
            cnt_q   <= 3'd0;
            count_q <= 32'd0;
            epc_q   <= 32'd0;
            trap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
            epc_q   <= epc_d;
            trap_q  <= trap_d;
        end
    end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit: a cycle-level reference model checked every negedge,
// plus literal expectations at key points of each scenario.
module tb_pc_redirect_unit;

    localparam logic [31:0] RESET_PC     = 32'h0000_2000;
    localparam logic [31:0] TRAP_PC      = 32'h0000_1000;
    localparam int unsigned FLUSH_CYCLES = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        x_valid = 1'b0;
    logic        x_pc_sel = 1'b0;
    logic        x_jalr = 1'b0;
    logic [31:0] x_target = 32'd0;
    logic        stall_in = 1'b0;
    logic        imem_ready = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        flush_fd;
    logic        trap_misalign;
    logic [31:0] trap_epc;
    logic [31:0] redirect_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pc_redirect_unit #(
        .RESET_PC     (RESET_PC),
        .TRAP_PC      (TRAP_PC),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .x_valid_i        (x_valid),
        .x_pc_sel_i       (x_pc_sel),
        .x_jalr_i         (x_jalr),
        .x_target_i       (x_target),
        .stall_in_i       (stall_in),
        .imem_ready_i     (imem_ready),
        .imem_req_o       (imem_req),
        .imem_addr_o      (imem_addr),
        .flush_fd_o       (flush_fd),
        .trap_misalign_o  (trap_misalign),
        .trap_epc_o       (trap_epc),
        .redirect_count_o (redirect_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    // Reference model: booting flag, remaining kill cycles, plain PC arithmetic.
    bit          m_boot;
    int          m_left;
    logic [31:0] m_pc, m_epc, m_count;
    bit          m_trap;

    logic        m_r;
    logic [31:0] m_t;
    always_comb begin
        m_t = x_target;
        if (x_jalr) m_t[0] = 1'b0;
        m_r = x_valid && x_pc_sel && !stall_in && !m_boot;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_boot  <= 1'b1;
            m_left  <= 0;
            m_pc    <= RESET_PC;
            m_epc   <= 32'd0;
            m_count <= 32'd0;
            m_trap  <= 1'b0;
        end else begin
            m_boot <= 1'b0;
            m_trap <= m_r && (m_t % 4 != 0);
            if (m_r) begin
                m_count <= m_count + 1;
                m_left  <= FLUSH_CYCLES - 1;
                if (m_t % 4 != 0) begin
                    m_pc  <= TRAP_PC;
                    m_epc <= m_t;
                end else begin
                    m_pc  <= m_t;
                end
            end else begin
                if (!stall_in && m_left > 0) m_left <= m_left - 1;
                if (!m_boot && imem_ready && !stall_in) m_pc <= m_pc + 4;
            end
        end
    end

    always @(negedge clk) begin
        check("model_imem_req", 32'(imem_req), 32'(!m_boot));
        check("model_imem_addr", imem_addr, m_pc);
        check("model_flush_fd", 32'(flush_fd), 32'(m_boot || m_left > 0 || m_r));
        check("model_trap", 32'(trap_misalign), 32'(m_trap));
        check("model_epc", trap_epc, m_epc);
        check("model_count", redirect_count, m_count);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic drive_r(input logic jalr, input logic [31:0] tgt);
        x_valid  = 1'b1;
        x_pc_sel = 1'b1;
        x_jalr   = jalr;
        x_target = tgt;
    endtask

    task automatic clear_r();
        x_valid  = 1'b0;
        x_pc_sel = 1'b0;
        x_jalr   = 1'b0;
        x_target = 32'd0;
    endtask

    initial begin
        tick();
        tick();
        rst_n = 1'b1;
        // Boot cycle.
        neg();
        check("boot_req", 32'(imem_req), 32'd0);
        check("boot_flush", 32'(flush_fd), 32'd1);
        check("boot_addr", imem_addr, 32'h2000);
        tick();
        neg();
        check("run_addr0", imem_addr, 32'h2000);
        check("run_flush0", 32'(flush_fd), 32'd0);
        tick();
        neg();
        check("run_addr1", imem_addr, 32'h2004);
        tick();
        // Taken branch at 0x2008.
        drive_r(1'b0, 32'h2040);
        neg();
        check("br_addr", imem_addr, 32'h2008);
        check("br_flush_n", 32'(flush_fd), 32'd1);
        tick();
        clear_r();
        neg();
        check("br_tgt", imem_addr, 32'h2040);
        check("br_flush_n1", 32'(flush_fd), 32'd1);
        check("br_count", redirect_count, 32'd1);
        tick();
        neg();
        check("br_next", imem_addr, 32'h2044);
        check("br_flush_end", 32'(flush_fd), 32'd0);
        tick();
        // JALR clears bit 0.
        drive_r(1'b1, 32'h3001);
        tick();
        clear_r();
        neg();
        check("jalr_addr", imem_addr, 32'h3000);
        check("jalr_notrap", 32'(trap_misalign), 32'd0);
        tick();
        tick();
        // Misaligned target traps.
        drive_r(1'b0, 32'h2042);
        tick();
        clear_r();
        neg();
        check("mis_addr", imem_addr, 32'h1000);
        check("mis_trap", 32'(trap_misalign), 32'd1);
        check("mis_epc", trap_epc, 32'h2042);
        check("mis_count", redirect_count, 32'd3);
        tick();
        neg();
        check("mis_trap_pulse", 32'(trap_misalign), 32'd0);
        check("mis_epc_sticky", trap_epc, 32'h2042);
        tick();
        // Stall inside flush; requested redirects during the stall are suppressed.
        drive_r(1'b0, 32'h4000);
        tick();
        drive_r(1'b0, 32'h5000);
        stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            neg();
            check("stall_addr", imem_addr, 32'h4000);
            check("stall_flush", 32'(flush_fd), 32'd1);
            tick();
        end
        stall_in = 1'b0;
        clear_r();
        neg();
        check("stall_rel_flush", 32'(flush_fd), 32'd1);
        check("stall_count", redirect_count, 32'd4);
        tick();
        neg();
        check("stall_end_flush", 32'(flush_fd), 32'd0);
        check("stall_end_addr", imem_addr, 32'h4004);
        tick();
        // Backpressure holds the address.
        imem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            neg();
            check("bp_addr", imem_addr, 32'h4008);
            check("bp_req", 32'(imem_req), 32'd1);
            tick();
        end
        imem_ready = 1'b1;
        // Redirect while already flushing reloads the target.
        drive_r(1'b0, 32'h7000);
        tick();
        drive_r(1'b0, 32'h7100);
        tick();
        clear_r();
        neg();
        check("reload_addr", imem_addr, 32'h7100);
        check("reload_flush", 32'(flush_fd), 32'd1);
        tick();
        neg();
        check("reload_end", 32'(flush_fd), 32'd0);
        tick();
        // Reset in the middle of a flush.
        drive_r(1'b0, 32'h6000);
        tick();
        clear_r();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_flush", 32'(flush_fd), 32'd1);
        check("rst_addr", imem_addr, RESET_PC);
        check("rst_count", redirect_count, 32'd0);
        check("rst_epc", trap_epc, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        neg();
        check("post_rst_addr", imem_addr, 32'h2004);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
